write_back_stage: RTL and testbench

Final pipeline stage fed directly by the third decode pipeline register. Consumes its registered control bundle (`writeAd`, `ADR_MUX`, `write`, `PC_load`, `SPR_w/i/d`) together with ALU and memory data. It commits results to an 8-entry register file and the stack pointer register (SPR), and issues PC loads. A memory-wait handshake stalls the upstream pipeline while a memory-sourced operation waits for data.

---
 rtl/write_back_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_write_back_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_stage.sv
// write_back_stage: final pipeline stage. Commits ALU or memory data into an
// 8-entry register file, the stack pointer register (SPR) and the PC-load
// outputs. Memory-sourced ops that arrive before their data is ready are
// parked in a one-deep latch while the upstream pipeline is stalled.
//
// Handshake: MEM_DATA_IN is valid only in a cycle where MEM_READY=1. A memory
// op commits at the first rising edge that sees MEM_READY=1. STALL_OUT is high
// in every cycle in which that commit cannot happen yet, so upstream holds.
module write_back_stage #(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = 16'hFFFF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [2:0]            writeAd_IN,
    input  logic                  ADR_MUX_IN,
    input  logic                  write_IN,
    input  logic                  PC_load_IN,
    input  logic                  SPR_w_IN,
    input  logic                  SPR_i_IN,
    input  logic                  SPR_d_IN,
    input  logic [DATA_WIDTH-1:0] ALU_DATA_IN,
    input  logic [DATA_WIDTH-1:0] MEM_DATA_IN,
    input  logic                  MEM_READY,
    input  logic [2:0]            rdAdA_IN,
    input  logic [2:0]            rdAdB_IN,
    output logic [DATA_WIDTH-1:0] rdDataA_OUT,
    output logic [DATA_WIDTH-1:0] rdDataB_OUT,
    output logic [DATA_WIDTH-1:0] SPR_OUT,
    output logic                  PC_load_OUT,
    output logic [DATA_WIDTH-1:0] PC_value_OUT,
    output logic                  STALL_OUT,
    output logic                  o_dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    state_e                r_state;
    state_e                w_next_state;

    // Control bundle parked while waiting for memory data. ADR_MUX is not
    // stored: anything parked is by definition a memory op.
    logic [2:0]            r_wad;
    logic                  r_write;
    logic                  r_pc_load;
    logic                  r_spr_w;
    logic                  r_spr_i;
    logic                  r_spr_d;

    logic [DATA_WIDTH-1:0] r_regs [8];
    logic [DATA_WIDTH-1:0] r_spr;
    logic                  r_pc_load_out;
    logic [DATA_WIDTH-1:0] r_pc_value;

    logic                  w_in_active;
    logic                  w_in_mem_op;
    logic                  w_commit;
    logic                  w_latch;
    logic                  w_stall;
    logic [2:0]            w_eff_wad;
    logic                  w_eff_write;
    logic                  w_eff_pc_load;
    logic                  w_eff_spr_w;
    logic                  w_eff_spr_i;
    logic                  w_eff_spr_d;
    logic [DATA_WIDTH-1:0] w_eff_data;
    logic                  w_rf_we;
    logic [DATA_WIDTH-1:0] w_spr_next;

    assign w_in_active = write_IN | PC_load_IN | SPR_w_IN;
    assign w_in_mem_op = w_in_active & ADR_MUX_IN;

    // State register: IDLE accepts new ops, WAIT holds a parked memory op.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus the effective op (live inputs in IDLE, parked bundle in WAIT).
    always_comb begin
        w_next_state  = r_state;
        w_commit      = 1'b0;
        w_latch       = 1'b0;
        w_stall       = 1'b0;
        w_eff_wad     = writeAd_IN;
        w_eff_write   = write_IN;
        w_eff_pc_load = PC_load_IN;
        w_eff_spr_w   = SPR_w_IN;
        w_eff_spr_i   = SPR_i_IN;
        w_eff_spr_d   = SPR_d_IN;
        w_eff_data    = ADR_MUX_IN ? MEM_DATA_IN : ALU_DATA_IN;
        case (r_state)
            S_IDLE: begin
                if (w_in_mem_op && !MEM_READY) begin
                    // Data not here yet: park the whole op, including i/d.
                    w_latch      = 1'b1;
                    w_stall      = 1'b1;
                    w_next_state = S_WAIT;
                end else begin
                    w_commit = 1'b1;
                end
            end
            S_WAIT: begin
                w_eff_wad     = r_wad;
                w_eff_write   = r_write;
                w_eff_pc_load = r_pc_load;
                w_eff_spr_w   = r_spr_w;
                w_eff_spr_i   = r_spr_i;
                w_eff_spr_d   = r_spr_d;
                w_eff_data    = MEM_DATA_IN;
                if (MEM_READY) begin
                    w_commit     = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Park the control bundle when a memory op must wait for its data.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wad     <= 3'd0;
            r_write   <= 1'b0;
            r_pc_load <= 1'b0;
            r_spr_w   <= 1'b0;
            r_spr_i   <= 1'b0;
            r_spr_d   <= 1'b0;
        end else if (w_latch) begin
            r_wad     <= writeAd_IN;
            r_write   <= write_IN;
            r_pc_load <= PC_load_IN;
            r_spr_w   <= SPR_w_IN;
            r_spr_i   <= SPR_i_IN;
            r_spr_d   <= SPR_d_IN;
        end
    end

    assign w_rf_we = w_commit & w_eff_write;

    // Register file write on commit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_rf_we) begin
            r_regs[w_eff_wad] <= w_eff_data;
        end
    end

    // SPR next value: write beats inc/dec; inc and dec together cancel.
    always_comb begin
        w_spr_next = r_spr;
        if (w_commit) begin
            if (w_eff_spr_w) begin
                w_spr_next = w_eff_data;
            end else if (w_eff_spr_i && w_eff_spr_d) begin
                w_spr_next = r_spr;
            end else if (w_eff_spr_i) begin
                w_spr_next = r_spr + ONE;
            end else if (w_eff_spr_d) begin
                w_spr_next = r_spr - ONE;
            end
        end
    end

    // SPR register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_spr <= SP_INIT;
        end else begin
            r_spr <= w_spr_next;
        end
    end

    // PC load pulse and target; target holds between loads.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc_load_out <= 1'b0;
            r_pc_value    <= '0;
        end else begin
            r_pc_load_out <= w_commit & w_eff_pc_load;
            if (w_commit && w_eff_pc_load) begin
                r_pc_value <= w_eff_data;
            end
        end
    end

    // Read ports with write-through bypass of the value being committed.
    always_comb begin
        rdDataA_OUT = r_regs[rdAdA_IN];
        rdDataB_OUT = r_regs[rdAdB_IN];
        if (w_rf_we && (rdAdA_IN == w_eff_wad)) begin
            rdDataA_OUT = w_eff_data;
        end
        if (w_rf_we && (rdAdB_IN == w_eff_wad)) begin
            rdDataB_OUT = w_eff_data;
        end
    end

    assign SPR_OUT      = r_spr;
    assign PC_load_OUT  = r_pc_load_out;
    assign PC_value_OUT = r_pc_value;
    assign STALL_OUT    = w_stall;
    assign o_dbg_state  = (r_state == S_WAIT);

endmodule

// File: tb/tb_write_back_stage.sv
// Directed testbench for write_back_stage with hand-computed expectations.
module tb_write_back_stage;

  logic        CLK;
  logic        RST_N;
  logic [2:0]  writeAd_IN;
  logic        ADR_MUX_IN;
  logic        write_IN;
  logic        PC_load_IN;
  logic        SPR_w_IN;
  logic        SPR_i_IN;
  logic        SPR_d_IN;
  logic [15:0] ALU_DATA_IN;
  logic [15:0] MEM_DATA_IN;
  logic        MEM_READY;
  logic [2:0]  rdAdA_IN;
  logic [2:0]  rdAdB_IN;
  logic [15:0] rdDataA_OUT;
  logic [15:0] rdDataB_OUT;
  logic [15:0] SPR_OUT;
  logic        PC_load_OUT;
  logic [15:0] PC_value_OUT;
  logic        STALL_OUT;
  logic        o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt;
  logic [15:0] exp_q[$];

  write_back_stage #(
    .DATA_WIDTH(16),
    .SP_INIT(16'hFFFF)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .writeAd_IN(writeAd_IN),
    .ADR_MUX_IN(ADR_MUX_IN),
    .write_IN(write_IN),
    .PC_load_IN(PC_load_IN),
    .SPR_w_IN(SPR_w_IN),
    .SPR_i_IN(SPR_i_IN),
    .SPR_d_IN(SPR_d_IN),
    .ALU_DATA_IN(ALU_DATA_IN),
    .MEM_DATA_IN(MEM_DATA_IN),
    .MEM_READY(MEM_READY),
    .rdAdA_IN(rdAdA_IN),
    .rdAdB_IN(rdAdB_IN),
    .rdDataA_OUT(rdDataA_OUT),
    .rdDataB_OUT(rdDataB_OUT),
    .SPR_OUT(SPR_OUT),
    .PC_load_OUT(PC_load_OUT),
    .PC_value_OUT(PC_value_OUT),
    .STALL_OUT(STALL_OUT),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // checking
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] wad, input logic mux, input logic wr,
                       input logic pcl, input logic sw, input logic si, input logic sd,
                       input logic [15:0] alu, input logic [15:0] mem, input logic rdy);
    writeAd_IN  = wad;
    ADR_MUX_IN  = mux;
    write_IN    = wr;
    PC_load_IN  = pcl;
    SPR_w_IN    = sw;
    SPR_i_IN    = si;
    SPR_d_IN    = sd;
    ALU_DATA_IN = alu;
    MEM_DATA_IN = mem;
    MEM_READY   = rdy;
  endtask

  task automatic nop(input logic rdy);
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, rdy);
  endtask

  initial begin
    RST_N    = 1'b1;
    rdAdA_IN = 3'd0;
    rdAdB_IN = 3'd0;
    nop(1'b0);

    // reset asserted mid-cycle, released away from the edge
    #3 RST_N = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rdAdA_IN = 3'(a);
      rdAdB_IN = 3'(a + 4);
      #1;
      check($sformatf("rst_reg%0d", a), rdDataA_OUT, 16'h0000);
      check($sformatf("rst_reg%0d", a + 4), rdDataB_OUT, 16'h0000);
    end
    check("rst_spr", SPR_OUT, 16'hFFFF);
    check("rst_pcl", 16'(PC_load_OUT), 16'h0000);
    check("rst_pcv", PC_value_OUT, 16'h0000);
    check("rst_stall", 16'(STALL_OUT), 16'h0000);
    check("rst_state", 16'(o_dbg_state), 16'h0000);

    // ALU write with same-cycle bypass
    tick();
    drive(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'hAAAA, 1'b0);
    rdAdA_IN = 3'd3;
    rdAdB_IN = 3'd4;
    #1;
    check("alu_bypass_a", rdDataA_OUT, 16'h1234);
    check("alu_other_b", rdDataB_OUT, 16'h0000);
    check("alu_stall", 16'(STALL_OUT), 16'h0000);
    tick();
    nop(1'b0);
    #1;
    check("alu_reg3", rdDataA_OUT, 16'h1234);
    check("alu_no_pcl", 16'(PC_load_OUT), 16'h0000);

    // SPR sequence d, d, i+d, i, i, i
    begin
      logic [1:0]  spr_ops [6];
      logic [15:0] spr_exp [6];
      spr_ops = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10};
      spr_exp = '{16'hFFFE, 16'hFFFD, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000};
      for (int k = 0; k < 6; k++) begin
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, spr_ops[k][1], spr_ops[k][0], 16'h0000, 16'h0000, 1'b0);
        tick();
        check($sformatf("spr_step%0d", k), SPR_OUT, spr_exp[k]);
      end
    end
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0);
    tick();
    check("spr_write_prio", SPR_OUT, 16'h0100);

    // non-memory PC load: one-cycle pulse, target holds
    drive(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4242, 16'h0000, 1'b0);
    tick();
    check("pc_pulse", 16'(PC_load_OUT), 16'h0001);
    check("pc_value", PC_value_OUT, 16'h4242);
    nop(1'b0);
    tick();
    check("pc_pulse_end", 16'(PC_load_OUT), 16'h0000);
    check("pc_value_hold", PC_value_OUT, 16'h4242);

    // memory wait: 3 cycles of MEM_READY low, garbage on inputs while parked
    stall_cnt = 0;
    drive(3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h1111, 1'b0);
    rdAdA_IN = 3'd5;
    rdAdB_IN = 3'd6;
    #1;
    stall_cnt += int'(STALL_OUT);
    check("mw_bypass_none", rdDataA_OUT, 16'h0000);
    tick();
    drive(3'd6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hDEAD, 16'h2222, 1'b0);
    #1;
    stall_cnt += int'(STALL_OUT);
    check("mw_wait_state", 16'(o_dbg_state), 16'h0001);
    check("mw_reg5_nocommit", rdDataA_OUT, 16'h0000);
    check("mw_nopcl1", 16'(PC_load_OUT), 16'h0000);
    tick();
    drive(3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hCAFE, 16'h3333, 1'b0);
    #1;
    stall_cnt += int'(STALL_OUT);
    check("mw_nopcl2", 16'(PC_load_OUT), 16'h0000);
    check("mw_reg6_nocommit", rdDataB_OUT, 16'h0000);
    tick();
    drive(3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hF00D, 16'hBEEF, 1'b1);
    #1;
    stall_cnt += int'(STALL_OUT);
    check("mw_ready_stall", 16'(STALL_OUT), 16'h0000);
    check("mw_ready_bypass", rdDataA_OUT, 16'hBEEF);
    check("mw_stall_cycles", 16'(stall_cnt), 16'd3);
    tick();
    nop(1'b0);
    #1;
    check("mw_reg5", rdDataA_OUT, 16'hBEEF);
    check("mw_reg6_untouched", rdDataB_OUT, 16'h0000);
    check("mw_pcl", 16'(PC_load_OUT), 16'h0001);
    check("mw_pcv", PC_value_OUT, 16'hBEEF);
    check("mw_spr_unchanged", SPR_OUT, 16'h0100);
    check("mw_idle", 16'(o_dbg_state), 16'h0000);
    tick();
    check("mw_single_pulse", 16'(PC_load_OUT), 16'h0000);

    // reset while parked in WAIT
    drive(3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5555, 1'b0);
    rdAdA_IN = 3'd2;
    #1;
    check("rw_enter_stall", 16'(STALL_OUT), 16'h0001);
    tick();
    nop(1'b0);
    #1;
    check("rw_in_wait", 16'(o_dbg_state), 16'h0001);
    check("rw_wait_stall", 16'(STALL_OUT), 16'h0001);
    #1 RST_N = 1'b0;
    #1;
    check("rw_state_idle", 16'(o_dbg_state), 16'h0000);
    check("rw_stall_low", 16'(STALL_OUT), 16'h0000);
    check("rw_spr", SPR_OUT, 16'hFFFF);
    check("rw_pcv", PC_value_OUT, 16'h0000);
    #1 RST_N = 1'b1;
    tick();
    nop(1'b1);
    MEM_DATA_IN = 16'hABCD;
    #1;
    check("rw_stall_after", 16'(STALL_OUT), 16'h0000);
    tick();
    nop(1'b0);
    #1;
    check("rw_reg2", rdDataA_OUT, 16'h0000);
    check("rw_no_pcl", 16'(PC_load_OUT), 16'h0000);

    // back-to-back memory writes with MEM_READY held high
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    drive(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9999, 16'h0011, 1'b1);
    rdAdA_IN = 3'd1;
    rdAdB_IN = 3'd2;
    #1;
    check("b2b_stall0", 16'(STALL_OUT), 16'h0000);
    tick();
    drive(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8888, 16'h0022, 1'b1);
    #1;
    check("b2b_stall1", 16'(STALL_OUT), 16'h0000);
    check("b2b_reg1", rdDataA_OUT, exp_q.pop_front());
    check("b2b_state1", 16'(o_dbg_state), 16'h0000);
    tick();
    nop(1'b0);
    #1;
    check("b2b_reg2", rdDataB_OUT, exp_q.pop_front());
    check("b2b_reg1_keep", rdDataA_OUT, 16'h0011);
    check("b2b_stall2", 16'(STALL_OUT), 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
